// File: rtl/telemetry_rx_if.sv
// Signal bundle between the telemetry serial line and its decoded register view.
// The receiver uses the slave modport; a bench or upstream model uses master.
interface telemetry_rx_if;
  logic        RX;
  logic [11:0] batt;
  logic [11:0] curr;
  logic [11:0] torque;
  logic        frame_vld;
  logic        frm_err;
  logic [2:0]  byte_cnt;
  logic [1:0]  uart_state;
  logic [1:0]  frm_state;

  // frame_vld and frm_err are single-cycle strobes with no ready/backpressure:
  // batt/curr/torque are valid from the frame_vld cycle until the next frame_vld.
  modport master (
    output RX,
    input  batt, curr, torque, frame_vld, frm_err, byte_cnt, uart_state, frm_state
  );

  modport slave (
    input  RX,
    output batt, curr, torque, frame_vld, frm_err, byte_cnt, uart_state, frm_state
  );
endinterface

// File: rtl/telemetry_rx.sv
// 8N1 UART receiver plus framer for the eBike 8-byte telemetry packet
// (AA 55 bH bL cH cL tH tL), publishing 12-bit readings atomically.
module telemetry_rx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input logic           clk,
  input logic           rst_n,
  telemetry_rx_if.slave bus
);

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [1:0] F_HDR1    = 2'd0;
  localparam logic [1:0] F_HDR2    = 2'd1;
  localparam logic [1:0] F_PAYLOAD = 2'd2;

  localparam logic [11:0] FULL_BIT = 12'(BAUD_DIV);
  localparam logic [11:0] HALF_BIT = 12'(BAUD_DIV / 2);

  // Synchroniser presets to idle-high so reset never fakes a start edge.
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  logic [1:0]  u_state_q, u_state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        brk_q, brk_d;
  logic        byte_rdy_q, byte_rdy_d;
  logic [7:0]  byte_q, byte_d;
  logic        uart_err_q, uart_err_d;
  logic        tick;

  assign tick = (cnt_q == 12'd1);

  always_comb begin
    u_state_d  = u_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    brk_d      = brk_q;
    byte_rdy_d = 1'b0;
    byte_d     = byte_q;
    uart_err_d = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        if (rx_fall) begin
          cnt_d     = HALF_BIT;
          u_state_d = U_START;
        end
      end
      U_START: begin
        if (tick) begin
          if (rx_sync_q) begin
            u_state_d = U_IDLE;
          end else begin
            cnt_d     = FULL_BIT;
            bit_idx_d = 3'd0;
            u_state_d = U_DATA;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      U_DATA: begin
        if (tick) begin
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          cnt_d     = FULL_BIT;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) u_state_d = U_STOP;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      default: begin
        // After a low stop bit, wait out the break so it cannot look like a start.
        if (brk_q) begin
          if (rx_sync_q) begin
            brk_d     = 1'b0;
            u_state_d = U_IDLE;
          end
        end else if (tick) begin
          if (rx_sync_q) begin
            byte_rdy_d = 1'b1;
            byte_d     = shreg_q;
            u_state_d  = U_IDLE;
          end else begin
            uart_err_d = 1'b1;
            brk_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_state_q  <= U_IDLE;
      cnt_q      <= 12'd0;
      bit_idx_q  <= 3'd0;
      shreg_q    <= 8'd0;
      brk_q      <= 1'b0;
      byte_rdy_q <= 1'b0;
      byte_q     <= 8'd0;
      uart_err_q <= 1'b0;
    end else begin
      u_state_q  <= u_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      brk_q      <= brk_d;
      byte_rdy_q <= byte_rdy_d;
      byte_q     <= byte_d;
      uart_err_q <= uart_err_d;
    end
  end

  logic [1:0]  f_state_q, f_state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [11:0] sh_batt_q, sh_batt_d;
  logic [11:0] sh_curr_q, sh_curr_d;
  logic [3:0]  sh_tq_hi_q, sh_tq_hi_d;
  logic [11:0] batt_q, batt_d;
  logic [11:0] curr_q, curr_d;
  logic [11:0] torque_q, torque_d;
  logic        frame_vld_q, frame_vld_d;
  logic        frm_err_q, frm_err_d;

  always_comb begin
    f_state_d   = f_state_q;
    bcnt_d      = bcnt_q;
    sh_batt_d   = sh_batt_q;
    sh_curr_d   = sh_curr_q;
    sh_tq_hi_d  = sh_tq_hi_q;
    batt_d      = batt_q;
    curr_d      = curr_q;
    torque_d    = torque_q;
    frame_vld_d = 1'b0;
    frm_err_d   = 1'b0;
    if (uart_err_q) begin
      frm_err_d = 1'b1;
      f_state_d = F_HDR1;
      bcnt_d    = 3'd0;
    end else if (byte_rdy_q) begin
      case (f_state_q)
        F_HDR1: begin
          if (byte_q == 8'hAA) f_state_d = F_HDR2;
        end
        F_HDR2: begin
          if (byte_q == 8'h55) begin
            f_state_d = F_PAYLOAD;
            bcnt_d    = 3'd0;
          end else if (byte_q != 8'hAA) begin
            frm_err_d = 1'b1;
            f_state_d = F_HDR1;
          end
        end
        F_PAYLOAD: begin
          // Even payload indices carry a high nibble whose pad must be zero.
          if (!bcnt_q[0] && (byte_q[7:4] != 4'h0)) begin
            frm_err_d = 1'b1;
            f_state_d = F_HDR1;
            bcnt_d    = 3'd0;
          end else if (bcnt_q == 3'd5) begin
            batt_d      = sh_batt_q;
            curr_d      = sh_curr_q;
            torque_d    = {sh_tq_hi_q, byte_q};
            frame_vld_d = 1'b1;
            f_state_d   = F_HDR1;
            bcnt_d      = 3'd0;
          end else begin
            case (bcnt_q)
              3'd0:    sh_batt_d[11:8] = byte_q[3:0];
              3'd1:    sh_batt_d[7:0]  = byte_q;
              3'd2:    sh_curr_d[11:8] = byte_q[3:0];
              3'd3:    sh_curr_d[7:0]  = byte_q;
              default: sh_tq_hi_d      = byte_q[3:0];
            endcase
            bcnt_d = bcnt_q + 3'd1;
          end
        end
        default: begin
          f_state_d = F_HDR1;
          bcnt_d    = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state_q   <= F_HDR1;
      bcnt_q      <= 3'd0;
      sh_batt_q   <= 12'd0;
      sh_curr_q   <= 12'd0;
      sh_tq_hi_q  <= 4'd0;
      batt_q      <= 12'd0;
      curr_q      <= 12'd0;
      torque_q    <= 12'd0;
      frame_vld_q <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      f_state_q   <= f_state_d;
      bcnt_q      <= bcnt_d;
      sh_batt_q   <= sh_batt_d;
      sh_curr_q   <= sh_curr_d;
      sh_tq_hi_q  <= sh_tq_hi_d;
      batt_q      <= batt_d;
      curr_q      <= curr_d;
      torque_q    <= torque_d;
      frame_vld_q <= frame_vld_d;
      frm_err_q   <= frm_err_d;
    end
  end

  assign bus.batt       = batt_q;
  assign bus.curr       = curr_q;
  assign bus.torque     = torque_q;
  assign bus.frame_vld  = frame_vld_q;
  assign bus.frm_err    = frm_err_q;
  assign bus.byte_cnt   = bcnt_q;
  assign bus.uart_state = u_state_q;
  assign bus.frm_state  = f_state_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Directed bench for telemetry_rx: a serial driver feeds packets while a monitor
// pops expected {err, batt, curr, torque} events whenever a strobe appears.
`timescale 1ns/1ps
module tb_telemetry_rx;
  localparam int  BAUD_DIV = 48;
  localparam real CLK_NS   = 20.0;
  localparam real BIT_NS   = BAUD_DIV * CLK_NS;
  localparam int  W        = 37;

  logic clk;
  logic rst_n;
  telemetry_rx_if bus();

  telemetry_rx #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] m_batt = 12'h0;
  logic [11:0] m_curr = 12'h0;
  logic [11:0] m_torque = 12'h0;

  // clock / reset block
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    bus.RX = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      #(bit_ns);
    end
    bus.RX = stop_bit;
    #(bit_ns);
    if (!stop_bit) begin
      bus.RX = 1'b1;
      #(bit_ns);
    end
  endtask

  task automatic send_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t,
                            input real bit_ns);
    exp_q.push_back({1'b0, b, c, t});
    m_batt = b;
    m_curr = c;
    m_torque = t;
    send_byte(8'hAA, 1'b1, bit_ns);
    send_byte(8'h55, 1'b1, bit_ns);
    send_byte({4'h0, b[11:8]}, 1'b1, bit_ns);
    send_byte(b[7:0], 1'b1, bit_ns);
    send_byte({4'h0, c[11:8]}, 1'b1, bit_ns);
    send_byte(c[7:0], 1'b1, bit_ns);
    send_byte({4'h0, t[11:8]}, 1'b1, bit_ns);
    send_byte(t[7:0], 1'b1, bit_ns);
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, m_batt, m_curr, m_torque});
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check({name, " pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (bus.frame_vld || bus.frm_err)) begin
      check("strobe exclusive", 64'(bus.frame_vld & bus.frm_err), 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected strobe: got vld=%b err=%b expected none",
                 bus.frame_vld, bus.frm_err);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("strobe event", 64'({bus.frm_err, bus.batt, bus.curr, bus.torque}), 64'(e));
      end
    end
  end

  initial begin
    logic [7:0] garbage [10];
    garbage = '{8'h13, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};

    bus.RX = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(negedge clk);
    check("reset outputs", 64'({bus.batt, bus.curr, bus.torque, bus.frame_vld,
                                bus.frm_err, bus.byte_cnt}), 64'd0);
    check("reset states", 64'({bus.uart_state, bus.frm_state}), 64'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(12'hABC, 12'h321, 12'hFFF, BIT_NS);
    drain("single frame");
    check("single frame hold", 64'({bus.batt, bus.curr, bus.torque}), 64'h0ABC321FFF);

    exp_q.push_back({1'b0, 12'h001, 12'h002, 12'h003});
    m_batt = 12'h001;
    m_curr = 12'h002;
    m_torque = 12'h003;
    foreach (garbage[i]) send_byte(garbage[i], 1'b1, BIT_NS);
    drain("leading garbage");

    send_byte(8'hAA, 1'b1, BIT_NS);
    send_byte(8'h55, 1'b1, BIT_NS);
    send_byte(8'h01, 1'b1, BIT_NS);
    push_err();
    send_byte(8'h23, 1'b0, BIT_NS);
    drain("bad stop");
    check("bad stop hold", 64'({bus.batt, bus.curr, bus.torque}), 64'h001002003);
    send_frame(12'h456, 12'h789, 12'hABC, BIT_NS);
    drain("after bad stop");

    push_err();
    send_byte(8'hAA, 1'b1, BIT_NS);
    send_byte(8'h55, 1'b1, BIT_NS);
    send_byte(8'h1A, 1'b1, BIT_NS);
    drain("pad nibble");
    check("pad nibble byte_cnt", 64'(bus.byte_cnt), 64'd0);
    check("pad nibble frm_state", 64'(bus.frm_state), 64'd0);

    bus.RX = 1'b0;
    #200;
    bus.RX = 1'b1;
    #(3 * BIT_NS);
    drain("glitch");
    check("glitch uart idle", 64'(bus.uart_state), 64'd0);

    send_byte(8'hAA, 1'b1, BIT_NS);
    send_byte(8'h55, 1'b1, BIT_NS);
    send_byte(8'h01, 1'b1, BIT_NS);
    send_byte(8'h02, 1'b1, BIT_NS);
    bus.RX = 1'b0;
    #(3 * BIT_NS);
    rst_n  = 1'b0;
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    check("mid reset outputs", 64'({bus.batt, bus.curr, bus.torque, bus.byte_cnt}), 64'd0);
    m_batt = 12'h0;
    m_curr = 12'h0;
    m_torque = 12'h0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(12'hF00, 12'h080, 12'h123, BIT_NS);
    drain("after reset");

    send_frame(12'h111, 12'h222, 12'h333, BIT_NS * 1.02);
    send_frame(12'h0A5, 12'h5A0, 12'hC3C, BIT_NS * 1.02);
    send_frame(12'h7FF, 12'h800, 12'h001, BIT_NS * 1.02);
    drain("back-to-back slow");
    send_frame(12'h444, 12'h555, 12'h666, BIT_NS * 0.98);
    send_frame(12'hFFF, 12'h000, 12'hFFF, BIT_NS * 0.98);
    send_frame(12'h9AB, 12'hCDE, 12'h0F1, BIT_NS * 0.98);
    drain("back-to-back fast");
    check("final hold", 64'({bus.batt, bus.curr, bus.torque}), 64'h9ABCDE0F1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/telemetry_rx.md
Name: telemetry_rx

Overview:
- Receiver for the eBike's serial telemetry line (TX output, 8N1 UART). Sits directly downstream of the eBike top level, on the bench/companion-board side.
- Recovers bytes, frames the 8-byte telemetry packet and presents the latest battery, current and torque readings as parallel 12-bit registers with a one-cycle valid strobe.
- Detects framing, header and format errors. Resynchronises on the next header.

Parameters:
- BAUD_DIV, 434, clk cycles per bit (50MHz / 115200). Legal range 16..4095.

Ports:
- clk  input  1  50MHz system clock
- rst_n  input  1  asynchronous active-low reset
- RX  input  1  serial telemetry in (eBike TX), idle high, asynchronous to clk
- batt  output  12  last valid battery reading
- curr  output  12  last valid current reading
- torque  output  12  last valid torque reading
- frame_vld  output  1  one-cycle pulse when batt/curr/torque update
- frm_err  output  1  one-cycle pulse: bad stop bit, bad header, or nonzero pad nibble
- byte_cnt  output  3  index of the next expected payload byte (debug)

Behaviour:
- Reset: all outputs 0. RX synchroniser preset to 1 (idle). Both FSMs go to IDLE / HDR1. Reset mid-byte or mid-frame abandons it with no output change.
- Synchronisation: RX passes through 2 flops, then an edge flop. Start is detected on a falling edge while the UART FSM is IDLE.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: on falling edge, load baud counter with BAUD_DIV/2 (integer divide) and go to START.
  - START: at counter expiry, sample RX.
    - If RX=1 (glitch): return to IDLE, no error.
    - Else: reload BAUD_DIV and go to DATA.
  - DATA: 8 samples, one per BAUD_DIV cycles. Right-shift, LSB first. Then go to STOP.
  - STOP: sample at mid-bit.
    - RX=1: byte_rdy pulses for 1 clk with the data, then IDLE.
    - RX=0: frm_err pulse, byte discarded. Remain in STOP until RX=1, then IDLE (no falsely detected start in a break).
- Byte latency: byte_rdy is asserted 9.5×BAUD_DIV ±3 clk after the start-bit falling edge at RX.
- Packet format (fixed, 8 bytes): 0xAA, 0x55, {4'h0,batt[11:8]}, batt[7:0], {4'h0,curr[11:8]}, curr[7:0], {4'h0,torque[11:8]}, torque[7:0].
- Frame FSM states: HDR1, HDR2, PAYLOAD. Advances only on byte_rdy.
  - HDR1: 0xAA → HDR2. Any other byte stays in HDR1 with no error (hunting).
  - HDR2:
    - 0x55 → PAYLOAD, byte_cnt=0.
    - 0xAA → stay in HDR2 (repeated header).
    - Other → frm_err, go to HDR1.
  - PAYLOAD: bytes go into a 6-byte shadow buffer at byte_cnt, then byte_cnt increments.
    - Even-index byte (high) with a nonzero upper nibble → frm_err, go to HDR1, shadow discarded.
    - byte_cnt==5 byte: on the cycle after byte_rdy, copy the shadow to batt/curr/torque atomically and pulse frame_vld for 1 clk. Go to HDR1, byte_cnt=0.
- UART framing error during PAYLOAD or HDR2: frame FSM returns to HDR1. Outputs hold their old values.
- Outputs change only on frame_vld. Partial frames never alter batt/curr/torque.
- frame_vld and frm_err are never asserted in the same cycle.
- Back-to-back frames with zero idle between stop and next start bit must be received without loss.

Test Plan:
- Single frame AA 55 0A BC 03 21 0F FF at BAUD_DIV=434 → one frame_vld pulse; batt=0xABC, curr=0x321, torque=0xFFF; frm_err never high.
- Leading garbage 13 AA AA 55 then payload 00 01 00 02 00 03 → frame_vld once; batt=1, curr=2, torque=3.
- Stop bit forced 0 on the 4th byte of a frame → frm_err pulse; no frame_vld; outputs keep previous values; the next clean frame decodes correctly.
- Payload high byte 1A (nonzero pad nibble) → frm_err; outputs unchanged; FSM back in HDR1 (byte_cnt=0).
- 200 ns low glitch on idle RX → no byte_rdy, no error. rst_n asserted mid-payload then released, followed by a clean frame → outputs 0 during reset, then correct values.
- Three frames back-to-back with zero gap, and the RX baud skewed ±2% → three frame_vld pulses with the correct values each.
